// File: rtl/aud_cfg_seq.sv
// aud_cfg_seq: sequences the seven-command audio codec init and single
// headphone-volume updates through an external I2C master, with NACK retries.
module aud_cfg_seq #(
  parameter logic [7:0] DEV_ADDR  = 8'h34,
  parameter int         T_DELAY   = 50,
  parameter int         MAX_RETRY = 3
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       vol_upd,
  input  logic [6:0] volume,
  input  logic       mute,
  input  logic       isout,
  input  logic [3:0] sr_sel,
  output logic       i2c_start,
  input  logic       i2c_idle,
  input  logic       i2c_nack,
  output logic [7:0] addr1,
  output logic [6:0] addr2,
  output logic [8:0] data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       upd_ack,
  output logic [2:0] cmd_idx
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ISSUE,
    WAIT_BUSY,
    WAIT_IDLE,
    CHECK,
    GAP
  } state_t;

  localparam logic [7:0] DELAY_LOAD = 8'(T_DELAY);
  localparam logic [2:0] RETRY_LIM  = 3'(MAX_RETRY);

  state_t     state;
  logic [7:0] delay_cnt;
  logic [2:0] retry_cnt;
  logic       full_mode;
  logic       pending;

  // Codec command table: returns {register address, register data} for a command index
  function automatic logic [15:0] cmd_entry(input logic [2:0] idx,
                                            input logic [6:0] vol_code,
                                            input logic       mute_on,
                                            input logic       play,
                                            input logic [3:0] rate);
    logic [6:0] vol7;
    vol7 = mute_on ? 7'h2F : vol_code;
    case (idx)
      3'd0:    cmd_entry = {7'h06, 9'h001};
      3'd1:    cmd_entry = {7'h02, 1'b1, 1'b1, vol7};
      3'd2:    cmd_entry = {7'h04, 3'b000, ~play, play, 4'b0101};
      3'd3:    cmd_entry = {7'h05, 5'b00000, ~play, 3'b000};
      3'd4:    cmd_entry = {7'h07, 8'h01, ~play};
      3'd5:    cmd_entry = {7'h08, 3'b000, rate, 2'b00};
      default: cmd_entry = {7'h09, 9'h001};
    endcase
  endfunction

  // Sequencer FSM; every output is a register so the I2C master sees glitch-free values
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr1     <= DEV_ADDR;
      addr2     <= '0;
      data      <= '0;
      cmd_idx   <= '0;
      retry_cnt <= '0;
      delay_cnt <= '0;
      full_mode <= 1'b0;
      pending   <= 1'b0;
      i2c_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      upd_ack   <= 1'b0;
    end else begin
      i2c_start <= 1'b0;
      upd_ack   <= 1'b0;
      addr1     <= DEV_ADDR;
      // A volume request arriving mid-sequence is remembered and run afterwards
      if (state != IDLE && vol_upd) begin
        pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            {addr2, data} <= cmd_entry(3'd0, volume, mute, isout, sr_sel);
            cmd_idx   <= 3'd0;
            full_mode <= 1'b1;
            pending   <= 1'b0;
            retry_cnt <= '0;
            delay_cnt <= DELAY_LOAD;
            done      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b1;
            state     <= SETUP;
          end else if (vol_upd || pending) begin
            {addr2, data} <= cmd_entry(3'd1, volume, mute, isout, sr_sel);
            cmd_idx   <= 3'd1;
            full_mode <= 1'b0;
            pending   <= 1'b0;
            retry_cnt <= '0;
            delay_cnt <= DELAY_LOAD;
            err       <= 1'b0;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP, GAP: begin
          if (delay_cnt == '0) begin
            i2c_start <= 1'b1;
            state     <= ISSUE;
          end else begin
            delay_cnt <= delay_cnt - 8'd1;
          end
        end
        ISSUE: begin
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!i2c_idle) begin
            state <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (i2c_idle) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (!i2c_nack) begin
            if (full_mode && cmd_idx != 3'd6) begin
              {addr2, data} <= cmd_entry(cmd_idx + 3'd1, volume, mute, isout, sr_sel);
              cmd_idx   <= cmd_idx + 3'd1;
              retry_cnt <= '0;
              delay_cnt <= DELAY_LOAD;
              state     <= GAP;
            end else begin
              if (full_mode) begin
                done <= 1'b1;
              end else begin
                upd_ack <= 1'b1;
              end
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (retry_cnt < RETRY_LIM) begin
            {addr2, data} <= cmd_entry(cmd_idx, volume, mute, isout, sr_sel);
            retry_cnt <= retry_cnt + 3'd1;
            delay_cnt <= DELAY_LOAD;
            state     <= GAP;
          end else begin
            err     <= 1'b1;
            pending <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aud_cfg_seq.sv
// tb_aud_cfg_seq: drives aud_cfg_seq with an I2C master responder, directed
// vectors, hand-written corner sequences and randomized runs against a model.
module tb_aud_cfg_seq;

  localparam int T_DELAY   = 4;
  localparam int MAX_RETRY = 3;
  localparam int PERIOD    = 10;
  localparam int BUDGET    = 3000;

  typedef struct {
    string      name;
    bit         full;
    logic [6:0] vol;
    bit         mt;
    bit         io;
    logic [3:0] sr;
    logic [6:0] nackAddr;
    int         nackCnt;
    int         eTries;
    int         xfers;
    bit         eDone;
    bit         eErr;
    int         eAcks;
    logic [8:0] eVolData;
    logic [8:0] eModeData;
    logic [6:0] lastAddr;
  } vec_t;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       start;
  logic       vol_upd;
  logic [6:0] volume;
  logic       mute;
  logic       isout;
  logic [3:0] sr_sel;
  logic       i2c_start;
  logic       i2c_idle;
  logic       i2c_nack;
  logic [7:0] addr1;
  logic [6:0] addr2;
  logic [8:0] data;
  logic       busy;
  logic       done;
  logic       err;
  logic       upd_ack;
  logic [2:0] cmd_idx;

  int          checkCount = 0;
  int          passCount  = 0;
  logic [23:0] gotQ[$];
  logic [23:0] expQ[$];
  int          nackLeft[128];
  int          ackPulses     = 0;
  int          ackBase       = 0;
  int          startRun      = 0;
  int          maxStartWidth = 0;
  bit          modelDone     = 1'b0;
  bit          modelErr      = 1'b0;
  int          modelAcks     = 0;

  aud_cfg_seq #(
    .DEV_ADDR (8'h34),
    .T_DELAY  (T_DELAY),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .start    (start),
    .vol_upd  (vol_upd),
    .volume   (volume),
    .mute     (mute),
    .isout    (isout),
    .sr_sel   (sr_sel),
    .i2c_start(i2c_start),
    .i2c_idle (i2c_idle),
    .i2c_nack (i2c_nack),
    .addr1    (addr1),
    .addr2    (addr2),
    .data     (data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .upd_ack  (upd_ack),
    .cmd_idx  (cmd_idx)
  );

  // Free-running 100 MHz-style clock for the DUT
  always #(PERIOD/2) CLOCK_50 = ~CLOCK_50;

  // Codec register address for each command slot
  function automatic logic [6:0] addrOf(input int c);
    case (c)
      0:       return 7'h06;
      1:       return 7'h02;
      2:       return 7'h04;
      3:       return 7'h05;
      4:       return 7'h07;
      5:       return 7'h08;
      default: return 7'h09;
    endcase
  endfunction

  // Register data for each command slot, from the codec field meanings
  function automatic logic [8:0] specData(input int c, input logic [6:0] vol,
                                          input logic mt, input logic io,
                                          input logic [3:0] sr);
    int v;
    v = mt ? 'h2F : int'(vol);
    case (c)
      0:       return 9'h001;
      1:       return 9'(9'h180 + v);
      2:       return io ? 9'h015 : 9'h025;
      3:       return io ? 9'h000 : 9'h008;
      4:       return io ? 9'h002 : 9'h003;
      5:       return 9'(int'(sr) * 4);
      default: return 9'h001;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic clearPlan();
    foreach (nackLeft[i]) nackLeft[i] = 0;
  endtask

  // One-cycle request pulse, driven between clock edges
  task automatic pulse(input logic s, input logic v);
    @(negedge CLOCK_50);
    start   = s;
    vol_upd = v;
    @(negedge CLOCK_50);
    start   = 1'b0;
    vol_upd = 1'b0;
  endtask

  // Waits until busy has stayed low for three cycles, bounded by BUDGET
  task automatic waitIdle(input string name);
    int quiet;
    int cycles;
    quiet  = 0;
    cycles = 0;
    while (quiet < 3 && cycles < BUDGET) begin
      @(negedge CLOCK_50);
      cycles++;
      if (busy === 1'b0) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) begin
      checkCount++;
      $display("[TB] FAIL %s timeout: busy 0x%0h after %0d cycles, expected 0x0", name, busy, BUDGET);
    end
  endtask

  function automatic logic [8:0] dataFor(input logic [6:0] a);
    foreach (gotQ[k]) if (gotQ[k][15:9] == a) return gotQ[k][8:0];
    return 9'bx;
  endfunction

  function automatic int countAddr(input logic [6:0] a);
    int n;
    n = 0;
    foreach (gotQ[k]) if (gotQ[k][15:9] == a) n++;
    return n;
  endfunction

  function automatic int badAddr1();
    int n;
    n = 0;
    foreach (gotQ[k]) if (gotQ[k][23:16] !== 8'h34) n++;
    return n;
  endfunction

  // Reference model: walks the command list, spending NACKs per command until ACK or exhaustion
  task automatic modelRun(input bit full, input bit withUpd, input int plan[7],
                          input logic [6:0] vol, input logic mt, input logic io,
                          input logic [3:0] sr);
    int left[7];
    int seq[$];
    int c;
    int tries;
    left = plan;
    expQ.delete();
    seq.delete();
    modelAcks = 0;
    modelErr  = 1'b0;
    if (full) begin
      seq = '{0, 1, 2, 3, 4, 5, 6};
      modelDone = 1'b0;
    end
    if (!full || withUpd) seq.push_back(1);
    foreach (seq[k]) begin
      c = seq[k];
      tries = (left[c] > MAX_RETRY) ? MAX_RETRY + 1 : left[c] + 1;
      repeat (tries) expQ.push_back({8'h34, addrOf(c), specData(c, vol, mt, io, sr)});
      if (left[c] > MAX_RETRY) begin
        left[c] -= tries;
        modelErr = 1'b1;
        break;
      end
      left[c] = 0;
      if (full && k == 6) modelDone = 1'b1;
      if ((full && k == 7) || (!full && k == 0)) modelAcks++;
    end
  endtask

  // I2C master responder: goes busy on each request, answers with the planned NACK/ACK
  initial begin
    logic [6:0] a;
    i2c_idle = 1'b1;
    i2c_nack = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      if (i2c_start === 1'b1) begin
        a = addr2;
        gotQ.push_back({addr1, addr2, data});
        i2c_idle = 1'b0;
        repeat ($urandom_range(5, 2)) @(negedge CLOCK_50);
        if (nackLeft[a] > 0) begin
          i2c_nack = 1'b1;
          nackLeft[a]--;
        end else begin
          i2c_nack = 1'b0;
        end
        i2c_idle = 1'b1;
      end
    end
  end

  // Monitor for upd_ack pulses and the width of each i2c_start pulse
  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (upd_ack === 1'b1) ackPulses++;
      if (i2c_start === 1'b1) begin
        startRun++;
        if (startRun > maxStartWidth) maxStartWidth = startRun;
      end else begin
        startRun = 0;
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    volume = v.vol;
    mute   = v.mt;
    isout  = v.io;
    sr_sel = v.sr;
    clearPlan();
    if (v.nackCnt > 0) nackLeft[v.nackAddr] = v.nackCnt;
    gotQ.delete();
    ackBase = ackPulses;
    pulse(v.full, !v.full);
    waitIdle(v.name);
  endtask

  initial begin
    vec_t    vecs[6];
    int      cyc;
    longint  t0;
    int      plan[7];
    bit      rFull;
    bit      rUpd;

    reset   = 1'b0;
    start   = 1'b0;
    vol_upd = 1'b0;
    volume  = 7'h00;
    mute    = 1'b0;
    isout   = 1'b1;
    sr_sel  = 4'h0;
    clearPlan();

    // Reset state
    repeat (3) @(negedge CLOCK_50);
    checkOutput("resetOutputs", {addr1, addr2, data, cmd_idx, i2c_start, busy, done, err, upd_ack},
                {8'h34, 7'h00, 9'h000, 3'h0, 5'b00000});
    @(negedge CLOCK_50);
    reset = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    checkOutput("idleAfterRelease", {busy, i2c_start, done, err}, 4'b0000);

    // Directed vectors
    vecs[0] = '{"ackAll",         1'b1, 7'h79, 1'b0, 1'b1, 4'h0, 7'h00, 0,   0, 7, 1'b1, 1'b0, 0, 9'h1F9, 9'h015, 7'h09};
    vecs[1] = '{"nackIdx3Twice",  1'b1, 7'h79, 1'b0, 1'b1, 4'h3, 7'h05, 2,   3, 9, 1'b1, 1'b0, 0, 9'h1F9, 9'h015, 7'h09};
    vecs[2] = '{"nackIdx2Always", 1'b1, 7'h79, 1'b0, 1'b1, 4'h3, 7'h04, 100, 4, 6, 1'b0, 1'b1, 0, 9'h1F9, 9'h015, 7'h04};
    vecs[3] = '{"volMuteUpd",     1'b0, 7'h79, 1'b1, 1'b1, 4'h3, 7'h00, 0,   0, 1, 1'b0, 1'b0, 1, 9'h1AF, 9'h000, 7'h02};
    vecs[4] = '{"recordPath",     1'b1, 7'h10, 1'b0, 1'b0, 4'hA, 7'h00, 0,   0, 7, 1'b1, 1'b0, 0, 9'h190, 9'h025, 7'h09};
    vecs[5] = '{"volNackOnce",    1'b0, 7'h05, 1'b0, 1'b0, 4'h0, 7'h02, 1,   2, 2, 1'b1, 1'b0, 1, 9'h185, 9'h000, 7'h02};

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      checkOutput({vecs[i].name, " transfers"}, gotQ.size(), vecs[i].xfers);
      checkOutput({vecs[i].name, " done"}, done, vecs[i].eDone);
      checkOutput({vecs[i].name, " err"}, err, vecs[i].eErr);
      checkOutput({vecs[i].name, " busy"}, busy, 0);
      checkOutput({vecs[i].name, " updAcks"}, ackPulses - ackBase, vecs[i].eAcks);
      checkOutput({vecs[i].name, " volData"}, dataFor(7'h02), vecs[i].eVolData);
      checkOutput({vecs[i].name, " addr1"}, badAddr1(), 0);
      if (vecs[i].full) checkOutput({vecs[i].name, " modeData"}, dataFor(7'h04), vecs[i].eModeData);
      if (vecs[i].nackCnt > 0) checkOutput({vecs[i].name, " tries"}, countAddr(vecs[i].nackAddr), vecs[i].eTries);
      if (gotQ.size() > 0) checkOutput({vecs[i].name, " lastAddr"}, gotQ[gotQ.size()-1][15:9], vecs[i].lastAddr);
      if (vecs[i].full && vecs[i].nackCnt == 0) begin
        for (int k = 0; k < 7 && k < gotQ.size(); k++)
          checkOutput({vecs[i].name, " order"}, gotQ[k][15:9], addrOf(k));
      end
    end

    // Start-to-request latency, register hold while inputs change, start ignored while busy
    clearPlan();
    gotQ.delete();
    volume = 7'h33;
    mute   = 1'b0;
    isout  = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b1;
    @(posedge CLOCK_50);
    t0 = $time;
    @(negedge CLOCK_50);
    start = 1'b0;
    cyc = 0;
    while (i2c_start !== 1'b1 && cyc < 100) begin
      @(negedge CLOCK_50);
      cyc++;
    end
    checkOutput("startLatency", int'(($time - t0 - PERIOD/2) / PERIOD), T_DELAY + 1);
    cyc = 0;
    while (cmd_idx !== 3'd1 && cyc < BUDGET) begin
      @(negedge CLOCK_50);
      cyc++;
    end
    volume = 7'h44;
    pulse(1'b1, 1'b0);
    waitIdle("holdRun");
    checkOutput("holdRun transfers", gotQ.size(), 7);
    checkOutput("holdRun volData", dataFor(7'h02), 9'h1B3);
    checkOutput("holdRun done", done, 1);

    // Volume request during init with mute set runs once init is done
    clearPlan();
    gotQ.delete();
    volume  = 7'h22;
    mute    = 1'b1;
    ackBase = ackPulses;
    pulse(1'b1, 1'b0);
    repeat (10) @(negedge CLOCK_50);
    pulse(1'b0, 1'b1);
    waitIdle("pendingUpd");
    checkOutput("pendingUpd transfers", gotQ.size(), 8);
    if (gotQ.size() > 0) checkOutput("pendingUpd last", gotQ[gotQ.size()-1], {8'h34, 7'h02, 9'h1AF});
    checkOutput("pendingUpd acks", ackPulses - ackBase, 1);
    checkOutput("pendingUpd doneErr", {done, err}, 2'b10);

    // start and vol_upd together: init only, request dropped
    gotQ.delete();
    mute    = 1'b0;
    ackBase = ackPulses;
    pulse(1'b1, 1'b1);
    waitIdle("startAndUpd");
    checkOutput("startAndUpd transfers", gotQ.size(), 7);
    checkOutput("startAndUpd acks", ackPulses - ackBase, 0);
    checkOutput("startAndUpd done", done, 1);

    // Reset while waiting for the master on command 4, then a clean restart
    clearPlan();
    gotQ.delete();
    pulse(1'b1, 1'b0);
    cyc = 0;
    while (!(cmd_idx === 3'd4 && i2c_start === 1'b0 && i2c_idle === 1'b0) && cyc < BUDGET) begin
      @(negedge CLOCK_50);
      cyc++;
    end
    checkOutput("reachIdx4Wait", cyc < BUDGET, 1);
    @(negedge CLOCK_50);
    reset = 1'b0;
    #1;
    checkOutput("midReset outputs", {addr1, addr2, data, cmd_idx, i2c_start, busy, done, err, upd_ack},
                {8'h34, 7'h00, 9'h000, 3'h0, 5'b00000});
    @(negedge CLOCK_50);
    checkOutput("midReset held", {addr1, addr2, data, cmd_idx, i2c_start, busy, done, err, upd_ack},
                {8'h34, 7'h00, 9'h000, 3'h0, 5'b00000});
    reset = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    gotQ.delete();
    pulse(1'b1, 1'b0);
    waitIdle("restart");
    checkOutput("restart transfers", gotQ.size(), 7);
    if (gotQ.size() > 0) checkOutput("restart first", gotQ[0][15:9], 7'h06);
    checkOutput("restart done", done, 1);

    // Randomized runs against the reference model
    for (int it = 0; it < 20; it++) begin
      volume = 7'($urandom);
      mute   = 1'($urandom_range(1, 0));
      isout  = 1'($urandom_range(1, 0));
      sr_sel = 4'($urandom);
      rFull  = (it == 0) || ($urandom_range(3, 0) != 0);
      rUpd   = rFull && ($urandom_range(1, 0) == 1);
      clearPlan();
      for (int c = 0; c < 7; c++) begin
        plan[c] = ($urandom_range(4, 0) == 0) ? int'($urandom_range(4, 1)) : 0;
        nackLeft[addrOf(c)] = plan[c];
      end
      modelRun(rFull, rUpd, plan, volume, mute, isout, sr_sel);
      gotQ.delete();
      ackBase = ackPulses;
      pulse(rFull, !rFull);
      if (rUpd) begin
        repeat ($urandom_range(15, 1)) @(negedge CLOCK_50);
        vol_upd = 1'b1;
        @(negedge CLOCK_50);
        vol_upd = 1'b0;
      end
      waitIdle("random");
      checkOutput("random transfers", gotQ.size(), expQ.size());
      for (int k = 0; k < expQ.size() && k < gotQ.size(); k++)
        checkOutput("random transfer", gotQ[k], expQ[k]);
      checkOutput("random done", done, modelDone);
      checkOutput("random err", err, modelErr);
      checkOutput("random acks", ackPulses - ackBase, modelAcks);
    end

    checkOutput("startPulseWidth", maxStartWidth, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
